// File: rtl/chess_turn_controller_pkg.sv
// Shared encodings for the chess clock: turn FSM states and side constants.
// The timers and the display logic use the same WHITE/BLACK values.
package chess_turn_controller_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WHITE_RUN = 3'd1,
    BLACK_RUN = 3'd2,
    PAUSED    = 3'd3,
    OVER      = 3'd4
  } turn_state_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

endpackage

// File: rtl/chess_turn_controller_if.sv
// Button, timer-expiry and timer-control signals between the turn controller
// and its surroundings (buttons, the two countdown timers, the display).
interface chess_turn_controller_if;
  logic start_btn;
  logic move_btn;
  logic white_timeout;
  logic black_timeout;
  logic white_flag;
  logic black_flag;
  logic turn;
  logic paused;
  logic game_over;
  logic winner;

  modport master (
    output start_btn, move_btn, white_timeout, black_timeout,
    input  white_flag, black_flag, turn, paused, game_over, winner
  );

  modport slave (
    input  start_btn, move_btn, white_timeout, black_timeout,
    output white_flag, black_flag, turn, paused, game_over, winner
  );
endinterface

// File: rtl/chess_turn_controller_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle pulse on the debounced rising edge.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] count;

  // The level flips on the Nth consecutive differing sample; the pulse is
  // registered alongside it, so raw edge to pulse is DEBOUNCE_CYCLES+2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      count  <= '0;
      pulse  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      pulse  <= 1'b0;
      if (sync_2 == level) begin
        count <= '0;
      end else if (count == LAST) begin
        count <= '0;
        level <= sync_2;
        pulse <= sync_2;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chess_turn_controller.sv
// Turn sequencing for a two-player chess clock: debounced start/move buttons
// drive a turn FSM that enables exactly one player's timer at a time.
//
//   state     | meaning
//   IDLE      | after reset, waiting for the first start press
//   WHITE_RUN | white to move, white timer enabled
//   BLACK_RUN | black to move, black timer enabled
//   PAUSED    | game started, both timers halted
//   OVER      | a running side's timer expired; only reset leaves
module chess_turn_controller
  import chess_turn_controller_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned DEBOUNCE_CYCLES = CLOCK_FREQUENCY / 1000 * DEBOUNCE_MS
) (
  input logic             clock,
  input logic             reset,
  chess_turn_controller_if.slave bus
);

  logic        start_pulse;
  logic        move_pulse;
  turn_state_t state_q, state_d;
  logic        turn_q, turn_d;
  logic        winner_q, winner_d;
  logic        white_q, black_q, paused_q, over_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clock (clock),
    .reset (reset),
    .raw   (bus.start_btn),
    .pulse (start_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_move_db (
    .clock (clock),
    .reset (reset),
    .raw   (bus.move_btn),
    .pulse (move_pulse)
  );

  // Priority within a running state: own timeout > move > start.
  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d = WHITE_RUN;
          turn_d  = WHITE;
        end
      end
      WHITE_RUN: begin
        if (bus.white_timeout) begin
          state_d  = OVER;
          winner_d = BLACK;
        end else if (move_pulse) begin
          state_d = BLACK_RUN;
          turn_d  = BLACK;
        end else if (start_pulse) begin
          state_d = PAUSED;
        end
      end
      BLACK_RUN: begin
        if (bus.black_timeout) begin
          state_d  = OVER;
          winner_d = WHITE;
        end else if (move_pulse) begin
          state_d = WHITE_RUN;
          turn_d  = WHITE;
        end else if (start_pulse) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (start_pulse) state_d = (turn_q == BLACK) ? BLACK_RUN : WHITE_RUN;
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      turn_q   <= WHITE;
      winner_q <= WHITE;
      white_q  <= 1'b0;
      black_q  <= 1'b0;
      paused_q <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      white_q  <= (state_d == WHITE_RUN);
      black_q  <= (state_d == BLACK_RUN);
      paused_q <= (state_d == PAUSED);
      over_q   <= (state_d == OVER);
    end
  end

  assign bus.white_flag = white_q;
  assign bus.black_flag = black_q;
  assign bus.turn       = turn_q;
  assign bus.paused     = paused_q;
  assign bus.game_over  = over_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Bench for chess_turn_controller with DEBOUNCE_CYCLES=4. Fixed latency used
// here: a clean raw press driven before edge 1 moves the flags on edge N+3=7.
module tb_chess_turn_controller;

  localparam int N = 4;

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_PAUSE = 2;
  localparam int PH_OVER  = 3;

  logic clock;
  logic reset;
  chess_turn_controller_if bus();

  chess_turn_controller #(.DEBOUNCE_CYCLES(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a game phase plus whose turn it is; each button is
  // a history of raw samples with a window-stability rule.
  int m_phase;
  bit m_turn, m_winner;
  bit s_lvl, mv_lvl, s_prev, mv_prev;
  bit sq[$];
  bit mq[$];

  function automatic bit window_differs(input bit q[$], input bit lvl);
    if (q.size() < N + 1) return 1'b0;
    for (int i = q.size() - 1 - N; i <= q.size() - 2; i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_turn = 0; m_winner = 0;
    s_lvl = 0; mv_lvl = 0; s_prev = 0; mv_prev = 0;
    sq.delete(); mq.delete();
    repeat (N + 1) begin sq.push_back(1'b0); mq.push_back(1'b0); end
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      bit s_new, m_new, own_to;
      case (m_phase)
        PH_IDLE: if (s_prev) begin m_phase = PH_RUN; m_turn = 0; end
        PH_RUN: begin
          own_to = m_turn ? bus.black_timeout : bus.white_timeout;
          if (own_to) begin m_phase = PH_OVER; m_winner = !m_turn; end
          else if (mv_prev) m_turn = !m_turn;
          else if (s_prev) m_phase = PH_PAUSE;
        end
        PH_PAUSE: if (s_prev) m_phase = PH_RUN;
        default: ;
      endcase
      s_new = 0;
      m_new = 0;
      if (window_differs(sq, s_lvl)) begin s_lvl = !s_lvl; s_new = s_lvl; end
      if (window_differs(mq, mv_lvl)) begin mv_lvl = !mv_lvl; m_new = mv_lvl; end
      sq.push_back(bus.start_btn);
      mq.push_back(bus.move_btn);
      while (sq.size() > N + 2) void'(sq.pop_front());
      while (mq.size() > N + 2) void'(mq.pop_front());
      s_prev = s_new;
      mv_prev = m_new;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      check("white_flag", bus.white_flag, m_phase == PH_RUN && m_turn == 0);
      check("black_flag", bus.black_flag, m_phase == PH_RUN && m_turn == 1);
      check("turn",       bus.turn,       m_turn);
      check("paused",     bus.paused,     m_phase == PH_PAUSE);
      check("game_over",  bus.game_over,  m_phase == PH_OVER);
      if (m_phase == PH_OVER) check("winner", bus.winner, m_winner);
      check("flag_excl", bus.white_flag & bus.black_flag, 1'b0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input bit is_move, input int hold);
    @(negedge clock);
    if (is_move) bus.move_btn = 1'b1; else bus.start_btn = 1'b1;
    idle(hold);
    if (is_move) bus.move_btn = 1'b0; else bus.start_btn = 1'b0;
    idle(N + 8);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    idle(3);
    #1 reset = 1'b1;
    idle(2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_white"},  bus.white_flag, 1'b0);
    check({tag, "_black"},  bus.black_flag, 1'b0);
    check({tag, "_turn"},   bus.turn,       1'b0);
    check({tag, "_paused"}, bus.paused,     1'b0);
    check({tag, "_over"},   bus.game_over,  1'b0);
    check({tag, "_winner"}, bus.winner,     1'b0);
  endtask

  initial begin
    int sc, mc;
    reset = 1'b0;
    bus.start_btn = 0; bus.move_btn = 0;
    bus.white_timeout = 0; bus.black_timeout = 0;
    idle(3);
    check_all_zero("reset");
    #1 reset = 1'b1;
    idle(2);

    // start: flags rise exactly on edge 7 after the raw press
    @(negedge clock);
    bus.start_btn = 1'b1;
    idle(6);
    check("start_early", bus.white_flag, 1'b0);
    idle(1);
    check("start_white", bus.white_flag, 1'b1);
    check("start_black", bus.black_flag, 1'b0);
    check("start_turn",  bus.turn,       1'b0);
    idle(3);
    bus.start_btn = 1'b0;
    idle(N + 8);

    press(1, 10);
    check("handoff_black", bus.black_flag, 1'b1);
    check("handoff_white", bus.white_flag, 1'b0);
    check("handoff_turn",  bus.turn,       1'b1);
    press(1, 10);
    check("return_white", bus.white_flag, 1'b1);
    check("return_turn",  bus.turn,       1'b0);

    for (int i = 0; i < 10; i++) begin
      bus.move_btn = !bus.move_btn;
      idle(2);
    end
    bus.move_btn = 1'b0;
    idle(N + 8);
    check("bounce_white", bus.white_flag, 1'b1);
    check("bounce_turn",  bus.turn,       1'b0);

    press(1, 10);
    press(0, 10);
    check("pause_paused", bus.paused,     1'b1);
    check("pause_black",  bus.black_flag, 1'b0);
    check("pause_white",  bus.white_flag, 1'b0);
    press(1, 10);
    check("pause_turn", bus.turn, 1'b1);
    press(0, 10);
    check("resume_black",  bus.black_flag, 1'b1);
    check("resume_paused", bus.paused,     1'b0);

    // timeout lands on the same edge the move pulse is acted on
    press(1, 10);
    @(negedge clock);
    bus.move_btn = 1'b1;
    idle(6);
    bus.white_timeout = 1'b1;
    idle(1);
    check("race_over",   bus.game_over,  1'b1);
    check("race_winner", bus.winner,     1'b1);
    check("race_white",  bus.white_flag, 1'b0);
    check("race_black",  bus.black_flag, 1'b0);
    idle(4);
    bus.move_btn = 1'b0;
    idle(N + 8);
    press(0, 10);
    press(1, 10);
    check("over_stuck", bus.game_over, 1'b1);
    bus.white_timeout = 1'b0;

    do_reset();
    press(0, 10);
    press(1, 10);
    check("pre_reset_black", bus.black_flag, 1'b1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1 check_all_zero("async_reset");
    idle(2);
    #1 reset = 1'b1;
    idle(N + 8);
    check("after_reset_white",  bus.white_flag, 1'b0);
    check("after_reset_paused", bus.paused,     1'b0);
    check("after_reset_over",   bus.game_over,  1'b0);

    for (int ep = 0; ep < 6; ep++) begin
      bus.start_btn = 0; bus.move_btn = 0;
      bus.white_timeout = 0; bus.black_timeout = 0;
      do_reset();
      sc = 0; mc = 0;
      for (int c = 0; c < 700; c++) begin
        @(negedge clock);
        if (sc == 0) begin
          bus.start_btn = ($urandom_range(0, 2) == 0);
          sc = $urandom_range(1, 14);
        end else sc--;
        if (mc == 0) begin
          bus.move_btn = ($urandom_range(0, 1) == 0);
          mc = $urandom_range(1, 12);
        end else mc--;
        if ($urandom_range(0, 299) == 0) bus.white_timeout = !bus.white_timeout;
        if ($urandom_range(0, 299) == 0) bus.black_timeout = !bus.black_timeout;
      end
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chess_turn_controller.md
Name: chess_turn_controller

Overview:
- Upstream control stage for the two per-player countdown timers.
- Debounces the start/pause and move push-buttons and runs a turn FSM.
- Drives each timer's run-enable flag, so exactly one player's clock runs at a time.
- Consumes both timers' expiry signals and declares game over with a winner.

Parameters:
- CLOCK_FREQUENCY, 50_000_000: input clock frequency in Hz.
- DEBOUNCE_MS, 20: time in ms a button must be stable before it is accepted.
- DEBOUNCE_CYCLES, CLOCK_FREQUENCY/1000*DEBOUNCE_MS: stable-cycle count. Benches may override it directly.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- start_btn, input, 1: raw start/pause button, active-high, asynchronous to clock.
- move_btn, input, 1: raw "move done" button, active-high, asynchronous to clock.
- white_timeout, input, 1: white timer has reached 0:00. Level signal.
- black_timeout, input, 1: black timer has reached 0:00. Level signal.
- white_flag, output, 1: run-enable for the white timer.
- black_flag, output, 1: run-enable for the black timer.
- turn, output, 1: side to move, 0=white, 1=black.
- paused, output, 1: game has started and the clocks are halted.
- game_over, output, 1: a timer has expired.
- winner, output, 1: winning side (0=white, 1=black). Valid only while game_over=1.

Behaviour:
- Clocking and reset:
  - One clock (clock).
  - Reset is asynchronous and active-low (reset).
  - All flops clear immediately when reset=0, including mid-game.
- Reset values:
  - white_flag=0, black_flag=0, turn=0, paused=0, game_over=0, winner=0.
  - FSM in IDLE.
  - Debouncer counters 0; debounced levels 0.
- Button conditioning, per button:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level updates only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A one-cycle press pulse is generated on the 0->1 edge of the debounced level.
  - Latency from a clean raw edge to the pulse: DEBOUNCE_CYCLES+3 cycles (±1 is acceptable, but it must be fixed and documented in the testbench).
- FSM states: IDLE, WHITE_RUN, BLACK_RUN, PAUSED, OVER.
  - IDLE: start pulse -> WHITE_RUN. Move pulse is ignored.
  - WHITE_RUN:
    - white_timeout=1 -> OVER, winner=1.
    - Otherwise a move pulse -> BLACK_RUN, turn=1.
    - Otherwise a start pulse -> PAUSED.
  - BLACK_RUN: mirror of WHITE_RUN (timeout gives winner=0; move goes to WHITE_RUN with turn=0).
  - PAUSED:
    - Start pulse -> WHITE_RUN or BLACK_RUN according to turn.
    - Move pulse is ignored; turn does not change while paused.
    - Timeouts are ignored, since both timers are halted.
  - OVER: terminal. Only reset exits.
- Outputs are registered (Moore), updating the cycle after the state transition:
  - white_flag=1 only in WHITE_RUN.
  - black_flag=1 only in BLACK_RUN.
  - paused=1 only in PAUSED.
  - game_over=1 only in OVER.
- Priority when events coincide in the same cycle: timeout > move > start.
  - A timeout of the running side wins over a simultaneous move (the flag fell first).
  - A timeout of the non-running side is ignored.
  - Move and start pulses together: the move is taken, the start is dropped.
- Invariant: white_flag & black_flag is never 1.

Decomposition:
- Shared package: state encoding typedef (IDLE, WHITE_RUN, BLACK_RUN, PAUSED, OVER) and the side constants WHITE=0, BLACK=1. The timers and the display logic use the same constants.
- One sub-module: button_debouncer, parameterised by DEBOUNCE_CYCLES, containing the synchroniser, stability counter, debounced level and rising-edge pulse. It is instantiated twice.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).

Test Plan (DEBOUNCE_CYCLES overridden to 4):
- Start game: release reset, hold start_btn high for 10 cycles -> within 7 cycles of the press, white_flag=1, black_flag=0, turn=0.
- Turn handoff: in WHITE_RUN, press move_btn for 10 cycles -> white_flag falls and black_flag rises together, turn=1. A second press returns to white.
- Bounce rejection: toggle move_btn every 2 cycles for 20 cycles, then release -> no state change, flags unchanged.
- Pause/resume: in BLACK_RUN, press start -> both flags 0, paused=1. Press move -> turn stays 1. Press start -> black_flag=1, paused=0.
- Timeout race: in WHITE_RUN, assert white_timeout in the same cycle as the move pulse -> game_over=1, winner=1, both flags 0. Further button presses have no effect.
- Reset mid-game: pull reset low during BLACK_RUN -> all outputs are 0 before the next clock edge. After release, the FSM is in IDLE.
